operand_queue_reg: RTL and testbench
====================================

OPERAND_QUEUE_REG -- requirements
Module: operand_queue_reg

Interface
REQ-001 Parameter WIDTH, default 8, bit width of one operand.
REQ-002 Parameter NCH, default 2, operands captured per tuple (channel 0 = left, channel 1 = right).
REQ-003 Parameter DEPTH, default 2, tuple entries held; legal range 1..16, any integer.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 run  input  1  global run enable; when 0, the queue holds all state (no push, no pop).
REQ-007 capture  input  1  read-select strobe from the control unit requesting capture of operands_in.
REQ-008 operands_in  input  NCH*WIDTH  register-file read data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 flush  input  1  synchronous discard of all queued tuples.
REQ-010 capture_ready  output  1  a capture this cycle will be accepted.
REQ-011 operands_out  output  NCH*WIDTH  head tuple presented to the ALU.
REQ-012 out_valid  output  1  operands_out holds a valid tuple.
REQ-013 out_ready  input  1  consumer accepts the head tuple this cycle.
REQ-014 count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-015 overflow  output  1  sticky flag: a capture was dropped.

Function
REQ-016 push = capture & run & capture_ready & ~flush; pop = out_valid & out_ready & run & ~flush.
REQ-017 capture_ready SHALL be 1 when count < DEPTH, or when count == DEPTH and pop is asserted in the same cycle.
REQ-018 A pushed tuple SHALL appear on operands_out with out_valid=1 on the cycle after the push if the queue was empty (1-cycle latency); it SHALL NOT combinationally bypass operands_in.
REQ-019 Order SHALL be FIFO across entries; all NCH channels of one tuple move together.
REQ-020 Write and read pointers SHALL wrap from DEPTH-1 to 0, including for non-power-of-two DEPTH.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, at empty, at full, and at any intermediate occupancy.
REQ-022 At count == 0, out_valid = 0 and operands_out = 0 (all bits).
REQ-023 capture & run & ~capture_ready & ~flush SHALL drop the tuple, set overflow, and leave queue contents unchanged.
REQ-024 overflow SHALL clear only on reset.
REQ-025 When flush = 1 and run = 1: count, both pointers -> 0 next cycle; push and pop are suppressed that cycle; overflow is unchanged.
REQ-026 flush is ignored when run = 0.
REQ-027 run = 0 SHALL freeze pointers, count, storage, and overflow; capture and out_ready are ignored; outputs keep their current values.
REQ-028 count SHALL be a registered value, not derived combinationally from pointers.

Reset
REQ-029 reset = 0 SHALL asynchronously clear both pointers, count, overflow, and all storage entries to 0; out_valid = 0 and operands_out = 0.
REQ-030 Reset during any operation (mid-push, full, mid-flush) SHALL discard all tuples, with no partial state surviving.
REQ-031 Deassertion takes effect at the next rising clock; the first capture is accepted on the first edge with reset = 1.

Structure
REQ-032 A shared package SHALL hold the default constants OPQ_WIDTH = 8, OPQ_NCH = 2, OPQ_DEPTH = 2, plus a helper for the pointer width.
REQ-033 Pointer, count, full, and empty logic SHALL live in one sub-module, opq_ptr_ctrl (parameter DEPTH); storage and data muxing stay in operand_queue_reg.
REQ-034 No latches; storage is a flop array of DEPTH x NCH*WIDTH.

Verification
REQ-035 Reset, then capture with operands_in = {8'h3C, 8'hA5} and run = 1 -> next cycle out_valid = 1, operands_out = {8'h3C, 8'hA5}, count = 1.
REQ-036 DEPTH = 2, out_ready = 0: capture 8'h01, 8'h02, 8'h03 on successive cycles -> count = 2, third tuple dropped, overflow = 1, head = 8'h01 then 8'h02 after pops.
REQ-037 Full queue, capture 8'h77 with out_ready = 1 in the same cycle -> accepted, count stays 2, output order 8'h02 then 8'h77 (continuing the REQ-036 contents after one pop).
REQ-038 run = 0 with capture = 1 and out_ready = 1 for 3 cycles -> count, operands_out, and overflow unchanged.
REQ-039 count = 2, assert flush together with capture = 1 -> next cycle count = 0, out_valid = 0, operands_out = 0, overflow unchanged.
REQ-040 DEPTH = 3: stream 10 tuples 8'h10..8'h19 with out_ready toggling -> all 10 received in order, pointer wrap exercised, overflow = 0; pull reset low mid-stream -> outputs = 0 immediately.

Source files
------------

// File: rtl/operand_queue_reg_pkg.sv
// Shared defaults and helpers for the operand queue.
package operand_queue_reg_pkg;

  localparam int unsigned OPQ_WIDTH = 8;
  localparam int unsigned OPQ_NCH   = 2;
  localparam int unsigned OPQ_DEPTH = 2;

  // Pointer width for a queue of the given depth; a single entry still needs one bit.
  function automatic int unsigned opq_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/opq_ptr_ctrl.sv
// Read/write pointers, occupancy count and full/empty flags for the operand queue.
module opq_ptr_ctrl
  import operand_queue_reg_pkg::*;
#(
  parameter int unsigned DEPTH = OPQ_DEPTH,
  localparam int unsigned PW = opq_ptr_w(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  // Next pointer/count; clear wins, pointers wrap at DEPTH-1 for any depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Pointer, count and flag registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = full_q;
  assign empty_o  = empty_q;

endmodule

// File: rtl/operand_queue_reg.sv
// Operand tuple FIFO between register-file read and the ALU.
module operand_queue_reg
  import operand_queue_reg_pkg::*;
#(
  parameter int unsigned WIDTH = OPQ_WIDTH,
  parameter int unsigned NCH   = OPQ_NCH,
  parameter int unsigned DEPTH = OPQ_DEPTH,
  localparam int unsigned DW = NCH * WIDTH,
  localparam int unsigned PW = opq_ptr_w(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          capture,
  input  logic [DW-1:0] operands_in,
  input  logic          flush,
  output logic          capture_ready,
  output logic [DW-1:0] operands_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          clr;
  logic          drop;
  logic          overflow_q, overflow_d;

  // Handshake decode; a pop frees the slot a same-cycle capture needs when full.
  always_comb begin
    clr           = flush & run;
    pop           = ~empty & out_ready & run & ~flush;
    capture_ready = ~full | pop;
    push          = capture & run & capture_ready & ~flush;
    drop          = capture & run & ~capture_ready & ~flush;
    overflow_d    = overflow_q | drop;
  end

  opq_ptr_ctrl #(
    .DEPTH(DEPTH)
  ) u_ptr_ctrl (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clr_i   (clr),
    .wr_ptr_o(wr_ptr),
    .rd_ptr_o(rd_ptr),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Tuple storage; all channels of a tuple are written together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr] <= operands_in;
    end
  end

  // Sticky overflow, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  // Head presentation; zeroed while empty so stale entries never leak out.
  always_comb begin
    out_valid    = ~empty;
    operands_out = empty ? '0 : mem_q[rd_ptr];
  end

  assign overflow = overflow_q;

endmodule

// File: tb/tb_operand_queue_reg.sv
// Scoreboard bench for operand_queue_reg at DEPTH=2 and DEPTH=3.
module tb_operand_queue_reg;

  logic clock;

  logic        a_reset, a_run, a_capture, a_flush, a_out_ready;
  logic [15:0] a_operands_in, a_operands_out;
  logic        a_capture_ready, a_out_valid, a_overflow;
  logic [1:0]  a_count;

  logic        b_reset, b_run, b_capture, b_flush, b_out_ready;
  logic [15:0] b_operands_in, b_operands_out;
  logic        b_capture_ready, b_out_valid, b_overflow;
  logic [1:0]  b_count;

  logic [15:0] expa[$];
  logic [15:0] expb[$];
  int n_vec = 0;
  int n_err = 0;
  int recvb = 0;

  operand_queue_reg #(.WIDTH(8), .NCH(2), .DEPTH(2)) dut_a (
    .clock(clock), .reset(a_reset), .run(a_run), .capture(a_capture),
    .operands_in(a_operands_in), .flush(a_flush), .capture_ready(a_capture_ready),
    .operands_out(a_operands_out), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .count(a_count), .overflow(a_overflow)
  );

  operand_queue_reg #(.WIDTH(8), .NCH(2), .DEPTH(3)) dut_b (
    .clock(clock), .reset(b_reset), .run(b_run), .capture(b_capture),
    .operands_in(b_operands_in), .flush(b_flush), .capture_ready(b_capture_ready),
    .operands_out(b_operands_out), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .count(b_count), .overflow(b_overflow)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] tup(input logic [7:0] v);
    return {~v, v};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Monitor A: compare the head against the scoreboard on every accepted pop.
  always @(negedge clock) begin
    if (a_reset && a_run && a_out_valid && a_out_ready && !a_flush) begin
      if (expa.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL a_unexpected_pop: got %0h expected no tuple", a_operands_out);
      end else begin
        chk("a_head", 32'(a_operands_out), 32'(expa.pop_front()));
      end
    end
  end

  // Monitor B: same, also counting tuples received.
  always @(negedge clock) begin
    if (b_reset && b_run && b_out_valid && b_out_ready && !b_flush) begin
      recvb++;
      if (expb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected_pop: got %0h expected no tuple", b_operands_out);
      end else begin
        chk("b_head", 32'(b_operands_out), 32'(expb.pop_front()));
      end
    end
  end

  initial begin
    int bcnt;
    int sent;
    logic rdy;
    logic rpop;
    a_reset = 0; a_run = 0; a_capture = 0; a_flush = 0; a_out_ready = 0; a_operands_in = '0;
    b_reset = 0; b_run = 0; b_capture = 0; b_flush = 0; b_out_ready = 0; b_operands_in = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_a_valid", 32'(a_out_valid), 0);
    chk("rst_a_data", 32'(a_operands_out), 0);
    chk("rst_a_ovf", 32'(a_overflow), 0);
    chk("rst_b_count", 32'(b_count), 0);

    // First capture on the first edge with reset high
    cyc(); a_reset = 1; b_reset = 1; a_run = 1;
    a_capture = 1; a_operands_in = 16'h3CA5; expa.push_back(16'h3CA5);
    cyc(); a_capture = 0; a_out_ready = 1;
    @(negedge clock);
    chk("first_valid", 32'(a_out_valid), 1);
    chk("first_data", 32'(a_operands_out), 32'h3CA5);
    chk("first_count", 32'(a_count), 1);
    cyc(); a_out_ready = 0;
    @(negedge clock);
    chk("drain_count", 32'(a_count), 0);
    chk("drain_valid", 32'(a_out_valid), 0);
    chk("drain_data", 32'(a_operands_out), 0);

    // Fill to full, third capture dropped
    cyc(); a_capture = 1; a_operands_in = tup(8'h01); expa.push_back(tup(8'h01));
    cyc(); a_operands_in = tup(8'h02); expa.push_back(tup(8'h02));
    cyc(); a_operands_in = tup(8'h03);
    @(negedge clock);
    chk("full_count", 32'(a_count), 2);
    chk("full_not_ready", 32'(a_capture_ready), 0);
    chk("ovf_before_drop", 32'(a_overflow), 0);
    cyc(); a_capture = 0;
    @(negedge clock);
    chk("drop_count", 32'(a_count), 2);
    chk("drop_ovf", 32'(a_overflow), 1);
    chk("drop_head", 32'(a_operands_out), 32'(tup(8'h01)));

    // Capture while full and popping in the same cycle
    cyc(); a_capture = 1; a_operands_in = tup(8'h77); a_out_ready = 1; expa.push_back(tup(8'h77));
    @(negedge clock);
    chk("full_pop_ready", 32'(a_capture_ready), 1);
    cyc(); a_capture = 0; a_out_ready = 0;
    @(negedge clock);
    chk("pushpop_count", 32'(a_count), 2);
    chk("pushpop_head", 32'(a_operands_out), 32'(tup(8'h02)));
    cyc(); a_out_ready = 1;
    cyc();
    cyc(); a_out_ready = 0;
    @(negedge clock);
    chk("empty_again", 32'(a_count), 0);
    chk("ovf_sticky", 32'(a_overflow), 1);

    // run=0 freezes everything
    cyc(); a_capture = 1; a_operands_in = tup(8'h44); expa.push_back(tup(8'h44));
    cyc(); a_operands_in = tup(8'h55); expa.push_back(tup(8'h55));
    cyc(); a_run = 0; a_operands_in = tup(8'h99); a_out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("hold_count", 32'(a_count), 2);
      chk("hold_data", 32'(a_operands_out), 32'(tup(8'h44)));
      chk("hold_ovf", 32'(a_overflow), 1);
      cyc();
    end

    // Flush with a concurrent capture
    a_run = 1; a_flush = 1; a_operands_in = tup(8'hEE);
    cyc(); a_flush = 0; a_capture = 0; a_out_ready = 0; expa.delete();
    @(negedge clock);
    chk("flush_count", 32'(a_count), 0);
    chk("flush_valid", 32'(a_out_valid), 0);
    chk("flush_data", 32'(a_operands_out), 0);
    chk("flush_ovf", 32'(a_overflow), 1);

    // Flush ignored while run=0
    cyc(); a_capture = 1; a_operands_in = tup(8'h5A); expa.push_back(tup(8'h5A));
    cyc(); a_capture = 0; a_run = 0; a_flush = 1;
    cyc(); a_run = 1; a_flush = 0; a_out_ready = 1;
    @(negedge clock);
    chk("noflush_count", 32'(a_count), 1);
    cyc(); a_out_ready = 0;
    @(negedge clock);
    chk("a_final_count", 32'(a_count), 0);
    chk("a_sb_empty", 32'(expa.size()), 0);

    // DEPTH=3 stream of ten tuples, out_ready toggling every two cycles
    b_run = 1; bcnt = 0; sent = 0;
    for (int c = 0; c < 80 && (sent < 10 || recvb < 10); c++) begin
      cyc();
      b_out_ready = (c % 4) >= 2;
      rpop = b_out_ready && (bcnt > 0);
      rdy = (bcnt < 3) || rpop;
      if (sent < 10 && rdy) begin
        b_capture = 1;
        b_operands_in = tup(8'(8'h10 + sent));
        expb.push_back(tup(8'(8'h10 + sent)));
        sent++;
      end else begin
        b_capture = 0;
      end
      @(negedge clock);
      chk("b_count", 32'(b_count), 32'(bcnt));
      chk("b_ready", 32'(b_capture_ready), 32'(rdy));
      bcnt = bcnt + ((b_capture && rdy) ? 1 : 0) - (rpop ? 1 : 0);
    end
    cyc(); b_capture = 0; b_out_ready = 0;
    @(negedge clock);
    chk("b_received", 32'(recvb), 10);
    chk("b_ovf", 32'(b_overflow), 0);
    chk("b_count_end", 32'(b_count), 0);

    // Reset pulled mid-stream
    cyc(); b_capture = 1; b_operands_in = tup(8'h20); expb.push_back(tup(8'h20));
    cyc(); b_operands_in = tup(8'h21); expb.push_back(tup(8'h21));
    cyc(); b_capture = 0;
    @(negedge clock);
    chk("b_pre_rst_count", 32'(b_count), 2);
    cyc(); b_reset = 0;
    #1;
    chk("b_rst_count", 32'(b_count), 0);
    chk("b_rst_valid", 32'(b_out_valid), 0);
    chk("b_rst_data", 32'(b_operands_out), 0);
    expb.delete();
    cyc(); b_reset = 1; b_capture = 1; b_operands_in = tup(8'h30); expb.push_back(tup(8'h30));
    cyc(); b_capture = 0; b_out_ready = 1;
    @(negedge clock);
    chk("b_post_rst_count", 32'(b_count), 1);
    cyc(); b_out_ready = 0;
    @(negedge clock);
    chk("b_sb_empty", 32'(expb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
